// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bus of the arbiter: request/data in, grant/select/status out.
interface mux4_rr_arbiter_if;
    import mux4_rr_arbiter_pkg::*;

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  d;
    logic [NREQ-1:0]  gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             y;
    logic             timeout;

    modport master (
        output req, d,
        input  gnt, sel, busy, y, timeout
    );

    modport slave (
        input  req, d,
        output gnt, sel, busy, y, timeout
    );

endinterface

// File: rtl/mux4.sv
// Existing 4:1 bit-select mux of the datapath.
module mux4 (
    input  logic [3:0] d,
    input  logic [1:0] s,
    output logic       y
);

    assign y = d[s];

endmodule

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotate-priority encoder: first requester at or after ptr.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [SEL_W-1:0]  off;

    // rot[j] is req[(ptr + j) mod 4], so the lowest set bit is the winner offset
    assign dbl = {req, req};
    assign rot = dbl[ptr +: NREQ];

    always_comb begin
        off = 2'd3;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
    end

    assign idx = ptr + off;
    assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for the 4:1 bit-select mux with optional max-hold release.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux4_rr_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] win_idx;
    logic [CNT_W-1:0] hold_cnt;
    logic [NREQ-1:0]  gnt_q;
    logic             busy_q;
    logic             timeout_q;
    logic             win_any;
    logic             rel_norm;
    logic             rel_force;
    logic             y_mux;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr),
        .idx (win_idx),
        .any (win_any)
    );

    assign rel_norm  = ~bus.req[sel_q];
    assign rel_force = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        state    <= ST_GRANT;
                        gnt_q    <= onehot(win_idx);
                        sel_q    <= win_idx;
                        busy_q   <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    // A normal drop wins over a simultaneous forced release: no timeout pulse
                    if (rel_norm || rel_force) begin
                        state     <= ST_IDLE;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        ptr       <= sel_q + 1'b1;
                        timeout_q <= ~rel_norm;
                    end else if (hold_cnt != CNT_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mux4 u_mux (
        .d (bus.d),
        .s (sel_q),
        .y (y_mux)
    );

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
    assign bus.y       = busy_q & y_mux;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one instance with MAX_HOLD=4, one with MAX_HOLD=0.
module tb_mux4_rr_arbiter;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [3:0] eg;

    mux4_rr_arbiter_if ifa ();
    mux4_rr_arbiter_if ifb ();

    mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_dut_h4 (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    mux4_rr_arbiter #(.MAX_HOLD(0), .CNT_W(8)) u_dut_h0 (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        ifa.req = 4'b1111;
        ifa.d   = 4'b1111;
        ifb.req = 4'b0000;
        ifb.d   = 4'b0000;

        // Reset held for three cycles with all requesters active
        #2 rst = 1'b1;
        #1;
        chk("rst_async_gnt", 8'(ifa.gnt), 8'h0);
        repeat (3) begin
            tick();
            chk("rst_gnt", 8'(ifa.gnt), 8'h0);
            chk("rst_sel", 8'(ifa.sel), 8'h0);
            chk("rst_busy", 8'(ifa.busy), 8'h0);
            chk("rst_y", 8'(ifa.y), 8'h0);
            chk("rst_timeout", 8'(ifa.timeout), 8'h0);
        end
        rst = 1'b0;
        tick();
        chk("first_gnt", 8'(ifa.gnt), 8'h1);
        chk("first_sel", 8'(ifa.sel), 8'h0);
        chk("first_busy", 8'(ifa.busy), 8'h1);

        // Continuous req=1111 with MAX_HOLD=4: order 0,1,2,3,0 with timeout idles
        for (int g = 0; g < 5; g++) begin
            eg = 4'b0001 << (g % 4);
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("rr_gnt_g%0d_c%0d", g, c), 8'(ifa.gnt), 8'(eg));
                chk($sformatf("rr_to_g%0d_c%0d", g, c), 8'(ifa.timeout), 8'h0);
                chk($sformatf("rr_y_g%0d_c%0d", g, c), 8'(ifa.y), 8'h1);
                tick();
            end
            chk($sformatf("rr_idle_gnt_g%0d", g), 8'(ifa.gnt), 8'h0);
            chk($sformatf("rr_idle_busy_g%0d", g), 8'(ifa.busy), 8'h0);
            chk($sformatf("rr_idle_to_g%0d", g), 8'(ifa.timeout), 8'h1);
            chk($sformatf("rr_idle_sel_g%0d", g), 8'(ifa.sel), 8'(g % 4));
            chk($sformatf("rr_idle_y_g%0d", g), 8'(ifa.y), 8'h0);
            tick();
        end
        chk("rr_next_gnt", 8'(ifa.gnt), 8'h2);
        ifa.req = 4'b0000;
        tick();
        chk("norm_rel_gnt", 8'(ifa.gnt), 8'h0);
        chk("norm_rel_to", 8'(ifa.timeout), 8'h0);
        chk("norm_rel_sel", 8'(ifa.sel), 8'h1);

        // Single requester 2, combinational y, drop, then ptr=3 picks 3 from 1100
        rst = 1'b1;
        #2 rst = 1'b0;
        chk("t2_rst_sel", 8'(ifa.sel), 8'h0);
        ifa.req = 4'b0100;
        ifa.d   = 4'b0100;
        tick();
        chk("t2_gnt", 8'(ifa.gnt), 8'h4);
        chk("t2_sel", 8'(ifa.sel), 8'h2);
        chk("t2_y_hi", 8'(ifa.y), 8'h1);
        ifa.d = 4'b0000;
        #1;
        chk("t2_y_lo", 8'(ifa.y), 8'h0);
        ifa.d   = 4'b0100;
        ifa.req = 4'b0000;
        tick();
        chk("t2_rel_gnt", 8'(ifa.gnt), 8'h0);
        chk("t2_rel_busy", 8'(ifa.busy), 8'h0);
        chk("t2_rel_y", 8'(ifa.y), 8'h0);
        chk("t2_rel_to", 8'(ifa.timeout), 8'h0);
        chk("t2_hold_sel", 8'(ifa.sel), 8'h2);
        ifa.req = 4'b1100;
        tick();
        chk("t2_ptr3_gnt", 8'(ifa.gnt), 8'h8);
        chk("t2_ptr3_sel", 8'(ifa.sel), 8'h3);

        // Pointer wrap 3 -> 0, then 0 -> 1 makes 3 win from 1001
        ifa.req = 4'b0000;
        tick();
        chk("t4_idle1", 8'(ifa.gnt), 8'h0);
        ifa.req = 4'b1001;
        tick();
        chk("t4_wrap_gnt", 8'(ifa.gnt), 8'h1);
        ifa.req = 4'b0000;
        tick();
        chk("t4_idle2", 8'(ifa.gnt), 8'h0);
        ifa.req = 4'b1001;
        tick();
        chk("t4_after0_gnt", 8'(ifa.gnt), 8'h8);
        ifa.req = 4'b0000;
        tick();
        chk("t4_idle3", 8'(ifa.gnt), 8'h0);

        // Asynchronous reset in the middle of a grant to requester 1
        ifa.req = 4'b0010;
        ifa.d   = 4'b0010;
        tick();
        chk("t5_gnt", 8'(ifa.gnt), 8'h2);
        chk("t5_y", 8'(ifa.y), 8'h1);
        #3 rst = 1'b1;
        #1;
        chk("t5_async_gnt", 8'(ifa.gnt), 8'h0);
        chk("t5_async_busy", 8'(ifa.busy), 8'h0);
        chk("t5_async_y", 8'(ifa.y), 8'h0);
        chk("t5_async_sel", 8'(ifa.sel), 8'h0);
        #1 rst = 1'b0;
        tick();
        chk("t5_regrant_gnt", 8'(ifa.gnt), 8'h2);
        chk("t5_regrant_sel", 8'(ifa.sel), 8'h1);
        ifa.req = 4'b0000;
        tick();
        chk("t5_rel_gnt", 8'(ifa.gnt), 8'h0);
        rst = 1'b1;
        #2 rst = 1'b0;
        ifa.req = 4'b0110;
        tick();
        chk("t5_ptr_reset_gnt", 8'(ifa.gnt), 8'h2);
        ifa.req = 4'b0000;
        tick();

        // Unlimited hold: requester 0 keeps the grant for 300 cycles
        ifb.req = 4'b0001;
        ifb.d   = 4'b0001;
        tick();
        for (int k = 0; k < 300; k++) begin
            chk($sformatf("t6_gnt_%0d", k), 8'(ifb.gnt), 8'h1);
            chk($sformatf("t6_to_%0d", k), 8'(ifb.timeout), 8'h0);
            tick();
        end
        chk("t6_y", 8'(ifb.y), 8'h1);
        chk("t6_busy", 8'(ifb.busy), 8'h1);
        ifb.req = 4'b0000;
        tick();
        chk("t6_rel_gnt", 8'(ifb.gnt), 8'h0);
        chk("t6_rel_to", 8'(ifb.timeout), 8'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
